// File: rtl/alu_pkg.sv
// Shared width and operation encodings for the registered ALU.
// The multiplier op is only implemented when ALU_MUL_EN is defined.
package alu_pkg;

    localparam int ALU_W = 16;

    typedef enum logic [1:0] {
        ALU_NOP = 2'd0,
        ALU_ADD = 2'd1,
        ALU_SUB = 2'd2,
        ALU_MUL = 2'd3
    } alu_op_e;

endpackage

// File: rtl/alu_mul.sv
// Combinational WIDTH x WIDTH multiplier returning the low WIDTH bits.
module alu_mul #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] p
);

    // Self-determined width is WIDTH, so the high product bits are never formed.
    assign p = a * b;

endmodule

// File: rtl/alu.sv
// Registered ALU: ADD/SUB/(MUL) with 1-cycle latency and a registered zero flag.
// Define ALU_MUL_EN to build the multiplier; otherwise op 3 holds like NOP.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_in1,
    input  logic [WIDTH-1:0] i_in2,
    input  logic [1:0]       i_alu_op,
    output logic [WIDTH-1:0] o_alu_out,
    output logic             o_z
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] result;
    logic             load;

    assign sum  = i_in1 + i_in2;
    assign diff = i_in1 - i_in2;

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] prod;

    alu_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .a (i_in1),
        .b (i_in2),
        .p (prod)
    );
`endif

    always_comb begin
        load   = 1'b0;
        result = o_alu_out;
        case (alu_op_e'(i_alu_op))
            ALU_ADD: begin
                load   = 1'b1;
                result = sum;
            end
            ALU_SUB: begin
                load   = 1'b1;
                result = diff;
            end
`ifdef ALU_MUL_EN
            ALU_MUL: begin
                load   = 1'b1;
                result = prod;
            end
`endif
            default: begin
                load   = 1'b0;
                result = o_alu_out;
            end
        endcase
    end

    // Result and flag share one enable so o_z always describes o_alu_out.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_alu_out <= '0;
            o_z       <= 1'b1;
        end else if (load) begin
            o_alu_out <= result;
            o_z       <= (result == '0);
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed table-driven bench for alu, plus hand-written reset sequences.
module tb_alu;

    localparam int W = 16;
`ifdef ALU_MUL_EN
    localparam bit MUL = 1'b1;
`else
    localparam bit MUL = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [1:0]   op;
    logic [W-1:0] alu_out;
    logic         z;

    int n_cmp = 0;
    int n_bad = 0;

    alu #(.WIDTH(W)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_in1     (in1),
        .i_in2     (in2),
        .i_alu_op  (op),
        .o_alu_out (alu_out),
        .o_z       (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_out;
        logic         exp_z;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [W-1:0] exp_out, input logic exp_z);
        n_cmp++;
        if (alu_out !== exp_out || z !== exp_z) begin
            n_bad++;
            $display("FAIL %s: got out=0x%04h z=%b, expected out=0x%04h z=%b",
                     name, alu_out, z, exp_out, exp_z);
        end
    endtask

    task automatic drive(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op  = o;
        in1 = a;
        in2 = b;
    endtask

    initial begin
        vecs[0]  = '{"add_20_5",    2'd1, 16'd20,     16'd5,      16'd25,   1'b0};
        vecs[1]  = '{"add_23_25",   2'd1, 16'd23,     16'd25,     16'd48,   1'b0};
        vecs[2]  = '{"sub_12_24",   2'd2, 16'd12,     16'd24,     16'hFFF4, 1'b0};
        vecs[3]  = '{"sub_10_10",   2'd2, 16'd10,     16'd10,     16'h0000, 1'b1};
        vecs[4]  = '{"mul_3_25",    2'd3, 16'd3,      16'd25,     MUL ? 16'd75 : 16'd0, MUL ? 1'b0 : 1'b1};
        vecs[5]  = '{"add_wrap",    2'd1, 16'hFFFF,   16'd1,      16'h0000, 1'b1};
        vecs[6]  = '{"nop_hold_0",  2'd0, 16'h1234,   16'h5678,   16'h0000, 1'b1};
        vecs[7]  = '{"add_1_1",     2'd1, 16'd1,      16'd1,      16'd2,    1'b0};
        vecs[8]  = '{"nop_hold_2",  2'd0, 16'd7,      16'd7,      16'd2,    1'b0};
        vecs[9]  = '{"mul_trunc0",  2'd3, 16'h0100,   16'h0100,   MUL ? 16'h0000 : 16'd2, MUL ? 1'b1 : 1'b0};
        vecs[10] = '{"mul_ffff_sq", 2'd3, 16'hFFFF,   16'hFFFF,   MUL ? 16'h0001 : 16'd2, 1'b0};
        vecs[11] = '{"sub_0_1",     2'd2, 16'd0,      16'd1,      16'hFFFF, 1'b0};

        rst = 1'b1;
        drive(2'd1, 16'd1, 16'd1);
        #2;
        check("reset_async", 16'h0000, 1'b1);
        @(posedge clk); #1;
        check("reset_held_over_edge", 16'h0000, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back: a new op every cycle, checked one cycle later.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b);
            @(posedge clk); #1;
            check(vecs[i].name, vecs[i].exp_out, vecs[i].exp_z);
            @(negedge clk);
        end

        drive(2'd1, 16'd100, 16'd200);
        @(posedge clk); #1;
        check("add_100_200", 16'd300, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("rst_pulse_async", 16'h0000, 1'b1);
        #1 rst = 1'b0;
        drive(2'd1, 16'd3, 16'd4);
        @(posedge clk); #1;
        check("after_pulse_add", 16'd7, 1'b0);

        @(negedge clk);
        rst = 1'b1;
        drive(2'd1, 16'd5, 16'd5);
        @(posedge clk); #1;
        check("rst_wins_edge", 16'h0000, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        drive(2'd2, 16'd9, 16'd4);
        @(posedge clk); #1;
        check("first_op_after_rst", 16'd5, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
        $fatal(1);
    end

endmodule
